// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

   // One queued fetch result: the fetch address and the word returned for it
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } fetch_entry_t;

   localparam logic [31:0] INS_NOP = 32'h0000_0013;
   localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: DEPTH-entry circular buffer with push, pop and flush.
// DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t wr_data,
   output fetch_entry_t rd_data,
   output logic         full,
   output logic         empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);
   localparam logic [PW-1:0] ONE_PTR  = PW'(1);

   fetch_entry_t  entries_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;

   assign rd_data = entries_q[rd_ptr_q];
   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);

   // Entry storage: written at the tail on push; flush keeps contents but they become unreachable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
      end else if (push && !flush) begin
         entries_q[wr_ptr_q] <= wr_data;
      end
   end

   // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + ONE_PTR;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + ONE_PTR;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + ONE_CNT;
            2'b01:   count_q <= count_q - ONE_CNT;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC generation, redirect/fault handling and a
// decoupling queue toward decode.
// Optional macro FETCH_PERF_CNT_EN adds fetch and stall performance counters.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pc_o,
   input  logic [31:0] ins_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        dec_valid_o,
   input  logic        dec_ready_i,
   output logic [31:0] dec_ins_o,
   output logic [31:0] dec_pc_o,
   output logic        fault_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_o,
   output logic [31:0] perf_stall_o
`endif
);

   logic [31:0]  pc_q;
   logic         fault_q;
   logic         full;
   logic         empty;
   logic         push;
   logic         pop;
   fetch_entry_t wr_entry;
   fetch_entry_t head;

   // Redirect wins over everything: it flushes the queue and suppresses push and pop
   assign pop      = !redirect_i && !empty && dec_ready_i;
   assign push     = !redirect_i && !fault_q && (!full || pop);
   assign wr_entry = '{pc: pc_q, ins: ins_i};

   assign pc_o        = pc_q;
   assign fault_o     = fault_q;
   assign dec_valid_o = !empty;
   assign dec_ins_o   = head.ins;
   assign dec_pc_o    = head.pc;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .flush   (redirect_i),
      .wr_data (wr_entry),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   // PC and fault: a misaligned target still loads pc_q but halts fetch until an aligned redirect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         fault_q <= 1'b0;
      end else if (redirect_i) begin
         pc_q    <= redirect_pc_i;
         fault_q <= |redirect_pc_i[1:0];
      end else if (push) begin
         pc_q    <= pc_q + PC_STEP;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_q;
   logic [31:0] perf_stall_q;
   logic        stall;

   assign stall        = !fault_q && !redirect_i && full && !pop;
   assign perf_fetch_o = perf_fetch_q;
   assign perf_stall_o = perf_stall_q;

   // Count pushes and full-queue stall cycles; both wrap modulo 2^32
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_q <= '0;
         perf_stall_q <= '0;
      end else begin
         if (push) begin
            perf_fetch_q <= perf_fetch_q + 32'd1;
         end
         if (stall) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (DEPTH=2, RESET_PC=0). Instruction memory
// word at byte address a is 32'hC0DE_0000 ^ (a >> 2).
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic [31:0] pc_o;
   logic [31:0] ins_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        dec_valid_o;
   logic        dec_ready_i;
   logic [31:0] dec_ins_o;
   logic [31:0] dec_pc_o;
   logic        fault_o;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_o;
   logic [31:0] perf_stall_o;
`endif

   int checks   = 0;
   int failures = 0;

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_o          (pc_o),
      .ins_i         (ins_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .dec_valid_o   (dec_valid_o),
      .dec_ready_i   (dec_ready_i),
      .dec_ins_o     (dec_ins_o),
      .dec_pc_o      (dec_pc_o),
      .fault_o       (fault_o)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch_o  (perf_fetch_o),
      .perf_stall_o  (perf_stall_o)
`endif
   );

   // Combinational instruction memory
   assign ins_i = 32'hC0DE_0000 ^ (pc_o >> 2);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst           = 1'b1;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;
      dec_ready_i   = 1'b1;
      #2;
      check("rst_pc", pc_o, 32'h0);
      check("rst_valid", {31'b0, dec_valid_o}, 32'h0);
      check("rst_fault", {31'b0, fault_o}, 32'h0);
      check("rst_ins", dec_ins_o, 32'h0);
      check("rst_decpc", dec_pc_o, 32'h0);

      // Reset release, streaming with ready=1
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("rel_pc1", pc_o, 32'h4);
      check("rel_valid1", {31'b0, dec_valid_o}, 32'h1);
      check("rel_decpc0", dec_pc_o, 32'h0);
      check("rel_ins0", dec_ins_o, 32'hC0DE_0000);
      tick();
      check("rel_pc2", pc_o, 32'h8);
      check("rel_decpc1", dec_pc_o, 32'h4);
      check("rel_ins1", dec_ins_o, 32'hC0DE_0001);
      tick();
      check("rel_decpc2", dec_pc_o, 32'h8);
      check("rel_ins2", dec_ins_o, 32'hC0DE_0002);

      // Redirect and pop in the same cycle: pop dropped, queue emptied
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0;
      tick();
      check("rp_valid", {31'b0, dec_valid_o}, 32'h0);
      check("rp_pc", pc_o, 32'h0);

      // Backpressure for 5 cycles: exactly two pushes
      redirect_i  = 1'b0;
      dec_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_decpc", dec_pc_o, 32'h0);
         check("bp_valid", {31'b0, dec_valid_o}, 32'h1);
      end
      check("bp_pc_hold", pc_o, 32'h8);
      check("bp_ins", dec_ins_o, 32'hC0DE_0000);

      // Release: order 4, 8, 12 after the held 0, no loss or duplication
      dec_ready_i = 1'b1;
      tick();
      check("rl_decpc4", dec_pc_o, 32'h4);
      tick();
      check("rl_decpc8", dec_pc_o, 32'h8);
      check("rl_ins8", dec_ins_o, 32'hC0DE_0002);
      tick();
      check("rl_decpc12", dec_pc_o, 32'hC);

      // Redirect to 0x100 with two entries queued
      dec_ready_i   = 1'b0;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h100;
      tick();
      check("rd_valid0", {31'b0, dec_valid_o}, 32'h0);
      check("rd_pc", pc_o, 32'h100);
      redirect_i  = 1'b0;
      dec_ready_i = 1'b1;
      tick();
      check("rd_valid1", {31'b0, dec_valid_o}, 32'h1);
      check("rd_decpc", dec_pc_o, 32'h100);
      check("rd_ins", dec_ins_o, 32'hC0DE_0040);

      // Misaligned redirect: fault, fetch halted
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h102;
      tick();
      check("mf_fault", {31'b0, fault_o}, 32'h1);
      check("mf_pc", pc_o, 32'h102);
      redirect_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mf_hold_pc", pc_o, 32'h102);
         check("mf_hold_valid", {31'b0, dec_valid_o}, 32'h0);
         check("mf_hold_fault", {31'b0, fault_o}, 32'h1);
      end
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h200;
      tick();
      check("mf_clear", {31'b0, fault_o}, 32'h0);
      check("mf_resume_pc", pc_o, 32'h200);
      redirect_i = 1'b0;
      tick();
      check("mf_resume_decpc", dec_pc_o, 32'h200);
      check("mf_resume_valid", {31'b0, dec_valid_o}, 32'h1);
      check("mf_resume_pc2", pc_o, 32'h204);

      // Redirect while head is valid and being popped; no stale entry afterward
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h300;
      tick();
      check("rp2_valid", {31'b0, dec_valid_o}, 32'h0);
      redirect_i = 1'b0;
      tick();
      check("rp2_decpc", dec_pc_o, 32'h300);
      check("rp2_ins", dec_ins_o, 32'hC0DE_00C0);

      // PC wrap at top of address space
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFC;
      tick();
      check("wr_pc", pc_o, 32'hFFFF_FFFC);
      redirect_i = 1'b0;
      tick();
      check("wr_pc_wrap", pc_o, 32'h0);
      check("wr_decpc", dec_pc_o, 32'hFFFF_FFFC);
      check("wr_ins", dec_ins_o, 32'hFF21_FFFF);
      tick();
      check("wr_decpc0", dec_pc_o, 32'h0);

      // Asynchronous reset mid-stream, sampled before the next edge
      #1;
      rst = 1'b1;
      #1;
      check("ar_valid", {31'b0, dec_valid_o}, 32'h0);
      check("ar_pc", pc_o, 32'h0);
      check("ar_decpc", dec_pc_o, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("ar_first_push", dec_pc_o, 32'h0);
      check("ar_pc_next", pc_o, 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog
   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the PC loaded at reset.
REQ-002 SHALL have parameter DEPTH, default 2, which is the fetch-queue entry count; legal values are 2 and 4.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 SHALL have port pc_o, output, 32 bits: fetch address driven to instruction memory.
REQ-006 SHALL have port ins_i, input, 32 bits: instruction returned combinationally by instruction memory for pc_o in the same cycle.
REQ-007 SHALL have port redirect_i, input, 1 bit: branch/jump redirect request from execute.
REQ-008 SHALL have port redirect_pc_i, input, 32 bits: redirect target.
REQ-009 SHALL have port dec_valid_o, output, 1 bit: the queue head holds a valid instruction for decode.
REQ-010 SHALL have port dec_ready_i, input, 1 bit: decode accepts the head this cycle.
REQ-011 SHALL have port dec_ins_o, output, 32 bits: head instruction.
REQ-012 SHALL have port dec_pc_o, output, 32 bits: PC of the head instruction.
REQ-013 SHALL have port fault_o, output, 1 bit: misaligned-target fault; fetch is halted while it is set.

Function
REQ-014 SHALL hold the fetch PC in register pc_q and drive pc_o = pc_q.
REQ-015 SHALL perform a push in a cycle when all of the following hold: no redirect, fault_o=0, and the queue is not full or a pop occurs in the same cycle.
REQ-016 SHALL, on a push, write the entry {pc_q, ins_i} to the queue tail and update pc_q <= pc_q + 4, where the addition is modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0).
REQ-017 SHALL perform a pop when dec_valid_o and dec_ready_i are both 1; the head then advances in the next cycle.
REQ-018 SHALL drive dec_valid_o = (count != 0), and SHALL drive dec_ins_o/dec_pc_o from the head entry.
REQ-019 SHALL hold dec_ins_o/dec_pc_o stable while dec_valid_o=1 and dec_ready_i=0.
REQ-020 SHALL support simultaneous push and pop at full, leaving count unchanged; push and pop at empty is impossible (pop requires valid).
REQ-021 SHALL give redirect_i priority over push and pop: queue cleared (count=0), pc_q <= redirect_pc_i, no push and no pop that cycle, and dec_ready_i ignored.
REQ-022 SHALL, on a redirect with redirect_pc_i[1:0] != 0, set fault_o=1 next cycle; pc_q still loads the target.
REQ-023 SHALL, while fault_o=1, push nothing, leave pc_q unchanged, and still drain and pop the queue (the queue is empty after the faulting redirect).
REQ-024 SHALL clear fault_o only by a redirect with an aligned target, which resumes fetch from that target the next cycle.
REQ-025 SHALL, after an aligned redirect, make the first instruction from the target visible on dec_* no earlier than 1 cycle after the redirect cycle, giving a redirect-to-valid latency of exactly 1 cycle when decode is empty.
REQ-026 SHALL, in steady state with dec_ready_i=1, sustain one instruction per cycle with no bubbles.

Reset
REQ-027 SHALL, while rst=1, asynchronously force pc_q=RESET_PC, count=0, dec_valid_o=0, fault_o=0, all queue entries to 0 (dec_ins_o=dec_pc_o=0), and counters to 0.
REQ-028 SHALL make the first push the first rising edge after rst deasserts, provided no redirect is present on that edge.

Configuration
REQ-029 SHALL, with macro FETCH_PERF_CNT_EN defined, add outputs perf_fetch_o (32 bits, pushes) and perf_stall_o (32 bits, cycles with fault_o=0 and no redirect where the queue is full and there is no pop); both wrap modulo 2^32 and are reset to 0.
REQ-030 SHALL, without FETCH_PERF_CNT_EN, have neither the perf ports nor the counter logic.

Structure
REQ-031 SHALL place fetch_entry_t (struct {pc[31:0], ins[31:0]}), constant INS_NOP = 32'h0000_0013 and constant PC_STEP = 4 in shared package fetch_pkg.
REQ-032 SHALL implement the queue as sub-module fetch_fifo (parameter DEPTH; push/pop/flush; wr/rd pointers plus count), instantiated once; the PC and fault logic stay in fetch_unit.

Verification
REQ-033 SHALL cover reset release with RESET_PC=0 and dec_ready_i=1: pc_o sequence 0,4,8; dec_pc_o 0,4,8 one cycle later; ins matches memory words 0,1,2.
REQ-034 SHALL cover backpressure with dec_ready_i=0 for 5 cycles, DEPTH=2: exactly 2 pushes, pc_o holds 8, dec_* stable at pc 0; on release, output in order 0,4,8 with no loss or duplication.
REQ-035 SHALL cover redirect to 32'h100 while the queue holds 2 entries: dec_valid_o=0 next cycle, then dec_pc_o=32'h100 with dec_ins_o = mem[64].
REQ-036 SHALL cover redirect to 32'h102: fault_o=1, no pushes, pc_o=32'h102 held; then redirect to 32'h200 clears fault_o and fetch resumes at 32'h200.
REQ-037 SHALL cover redirect and pop in the same cycle: the pop is dropped, the queue is empty, and no stale entry appears.
REQ-038 SHALL cover wrap with redirect to 32'hFFFF_FFFC: the next pc_o is 32'h0; and rst asserted mid-stream clears dec_valid_o immediately (asynchronously) and pc_o=RESET_PC.
